// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding constants: opcodes, NOP, field bit positions, shift-immediate funct3 codes.
package inst_encoder_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    localparam logic [2:0] SHAMT_F3_SLL = 3'b001;
    localparam logic [2:0] SHAMT_F3_SR  = 3'b101;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // True when v[31:msb] is a pure sign extension of v[msb].
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] s;
        s = $signed(v) >>> msb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_encode_comb.sv
// Pure combinational field pack plus immediate range check; an unencodable bundle yields NOP with err set.
module inst_encode_comb
    import inst_encoder_pkg::*;
(
    input  fields_t     f_i,
    output logic [31:0] inst_o,
    output logic        err_o
);

    logic [31:0] inst;
    logic        err;
    logic        is_shift;

    assign is_shift = (f_i.funct3 == SHAMT_F3_SLL) || (f_i.funct3 == SHAMT_F3_SR);

    always_comb begin
        inst = '0;
        err  = 1'b0;
        case (f_i.opcode)
            OPC_LUI, OPC_AUIPC: begin
                inst = {f_i.imm[31:12], f_i.rd, f_i.opcode};
                err  = |f_i.imm[11:0];
            end
            OPC_JAL: begin
                inst = {f_i.imm[20], f_i.imm[10:1], f_i.imm[11], f_i.imm[19:12], f_i.rd, f_i.opcode};
                err  = f_i.imm[0] || !fits_signed(f_i.imm, 20);
            end
            OPC_JALR: begin
                inst = {f_i.imm[11:0], f_i.rs1, 3'b000, f_i.rd, f_i.opcode};
                err  = (f_i.funct3 != 3'b000) || !fits_signed(f_i.imm, 11);
            end
            OPC_BRANCH: begin
                inst = {f_i.imm[12], f_i.imm[10:5], f_i.rs2, f_i.rs1, f_i.funct3,
                        f_i.imm[4:1], f_i.imm[11], f_i.opcode};
                err  = f_i.imm[0] || !fits_signed(f_i.imm, 12);
            end
            OPC_STORE: begin
                inst = {f_i.imm[11:5], f_i.rs2, f_i.rs1, f_i.funct3, f_i.imm[4:0], f_i.opcode};
                err  = !fits_signed(f_i.imm, 11);
            end
            OPC_LOAD: begin
                inst = {f_i.imm[11:0], f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
                err  = !fits_signed(f_i.imm, 11);
            end
            OPC_ARI_ITYPE: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit unsigned shamt.
                if (is_shift) begin
                    inst = {f_i.funct7, f_i.imm[4:0], f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
                    err  = |f_i.imm[31:5];
                end else begin
                    inst = {f_i.imm[11:0], f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
                    err  = !fits_signed(f_i.imm, 11);
                end
            end
            OPC_ARI_RTYPE: begin
                inst = '0;
                inst[F7_LSB  +: 7] = f_i.funct7;
                inst[RS2_LSB +: 5] = f_i.rs2;
                inst[RS1_LSB +: 5] = f_i.rs1;
                inst[F3_LSB  +: 3] = f_i.funct3;
                inst[RD_LSB  +: 5] = f_i.rd;
                inst[6:0]          = f_i.opcode;
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            inst = INST_NOP;
        end
    end

    assign inst_o = inst;
    assign err_o  = err;

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: S1 captures fields, S2 holds encoded word and err.
// Latency 2 cycles, 1/cycle throughput; in_ready is combinational from out_ready so a full pipe never bubbles.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic             s1_valid_q;
    fields_t          s1_fields_q;
    logic             out_valid_q;
    logic [31:0]      out_inst_q;
    logic             out_err_q;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic        s2_adv, s1_adv, in_fire, out_fire;
    logic [31:0] enc_inst;
    logic        enc_err;
    fields_t     in_fields;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign in_fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                         funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    inst_encode_comb u_enc (
        .f_i    (s1_fields_q),
        .inst_o (enc_inst),
        .err_o  (enc_err)
    );

    always_comb begin
        inst_cnt_d = inst_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (out_fire && (inst_cnt_q != '1)) begin
            inst_cnt_d = inst_cnt_q + CNT_W'(1);
        end
        if (out_fire && out_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
            inst_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q  <= 1'b1;
                s1_fields_q <= in_fields;
            end else if (s1_adv) begin
                s1_valid_q  <= 1'b0;
            end
            // S2 data only moves with a valid S1, so a stalled word stays put.
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_inst_q <= enc_inst;
                    out_err_q  <= enc_err;
                end
            end
            inst_cnt_q <= inst_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign inst_cnt  = inst_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: vector table, backpressure and reset sequences, random stream with model + round-trip decode.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    fields_t     in_f = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] inst_cnt, err_cnt;

    always #5 clk = ~clk;

    inst_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_f.opcode),
        .in_rd     (in_f.rd),
        .in_rs1    (in_f.rs1),
        .in_rs2    (in_f.rs2),
        .in_funct3 (in_f.funct3),
        .in_funct7 (in_f.funct7),
        .in_imm    (in_f.imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .inst_cnt  (inst_cnt),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
        fields_t     f;
    } exp_t;

    typedef struct {
        fields_t     f;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    exp_t        sbq[$];
    logic [15:0] exp_icnt = '0;
    logic [15:0] exp_ecnt = '0;
    logic        rnd_rdy = 1'b0;
    vec_t        tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic fields_t mk(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm);
        return '{opcode: opc, rd: rd, rs1: rs1, rs2: rs2, funct3: f3, funct7: f7, imm: imm};
    endfunction

    // Reference encoder written from signed ranges and shift/mask arithmetic.
    function automatic exp_t model(input fields_t f);
        exp_t        e;
        logic [31:0] i, w, rdo, rs1o, rs2o, f3o, f7o, opc;
        int          s;
        logic        err;
        i = f.imm;
        s = $signed(f.imm);
        rdo  = 32'(f.rd) << 7;
        rs1o = 32'(f.rs1) << 15;
        rs2o = 32'(f.rs2) << 20;
        f3o  = 32'(f.funct3) << 12;
        f7o  = 32'(f.funct7) << 25;
        opc  = 32'(f.opcode);
        err  = 1'b0;
        w    = 32'd0;
        case (f.opcode)
            OPC_LUI, OPC_AUIPC: begin
                err = (i & 32'hFFF) != 32'd0;
                w   = (i & 32'hFFFF_F000) | rdo | opc;
            end
            OPC_JAL: begin
                err = i[0] || s < -(1 << 20) || s >= (1 << 20);
                w   = (((i >> 20) & 32'd1) << 31) | (((i >> 1) & 32'h3FF) << 21) |
                      (((i >> 11) & 32'd1) << 20) | (((i >> 12) & 32'hFF) << 12) | rdo | opc;
            end
            OPC_JALR: begin
                err = f.funct3 != 3'd0 || s < -2048 || s > 2047;
                w   = ((i & 32'hFFF) << 20) | rs1o | rdo | opc;
            end
            OPC_BRANCH: begin
                err = i[0] || s < -4096 || s > 4095;
                w   = (((i >> 12) & 32'd1) << 31) | (((i >> 5) & 32'h3F) << 25) | rs2o | rs1o | f3o |
                      (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'd1) << 7) | opc;
            end
            OPC_STORE: begin
                err = s < -2048 || s > 2047;
                w   = (((i >> 5) & 32'h7F) << 25) | rs2o | rs1o | f3o | ((i & 32'h1F) << 7) | opc;
            end
            OPC_LOAD: begin
                err = s < -2048 || s > 2047;
                w   = ((i & 32'hFFF) << 20) | rs1o | f3o | rdo | opc;
            end
            OPC_ARI_ITYPE: begin
                if (f.funct3 == 3'd1 || f.funct3 == 3'd5) begin
                    err = i > 32'd31;
                    w   = f7o | (i << 20) | rs1o | f3o | rdo | opc;
                end else begin
                    err = s < -2048 || s > 2047;
                    w   = ((i & 32'hFFF) << 20) | rs1o | f3o | rdo | opc;
                end
            end
            OPC_ARI_RTYPE: w = f7o | rs2o | rs1o | f3o | rdo | opc;
            default:       err = 1'b1;
        endcase
        e.inst = err ? 32'h0000_0013 : w;
        e.err  = err;
        e.f    = f;
        return e;
    endfunction

    // Immediate extraction as the decoder would do it.
    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        case (w[6:0])
            OPC_LUI, OPC_AUIPC: return {w[31:12], 12'd0};
            OPC_JAL:            return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            OPC_BRANCH:         return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            OPC_STORE:          return {{20{w[31]}}, w[31:25], w[11:7]};
            OPC_ARI_ITYPE:      return (w[13:12] == 2'b01) ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
            default:            return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_output: got %h, expected no word", out_inst);
                end else begin
                    e = sbq.pop_front();
                    chk("out_inst", out_inst, e.inst);
                    chk("out_err", 32'(out_err), 32'(e.err));
                    if (!e.err && e.f.opcode != OPC_ARI_RTYPE) begin
                        chk("imm_roundtrip", dec_imm(out_inst), e.f.imm);
                        chk("rd_roundtrip", 32'(out_inst[11:7]),
                            (e.f.opcode == OPC_STORE || e.f.opcode == OPC_BRANCH) ? 32'(out_inst[11:7]) ^ 32'd0 : 32'(e.f.rd));
                    end
                    exp_icnt++;
                    if (e.err) exp_ecnt++;
                end
            end
        end
    endtask

    task automatic send(input fields_t f, input exp_t e);
        bit done;
        done = 1'b0;
        in_f = f;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) begin
            n_cmp++;
            n_mis++;
            $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 300 && sbq.size() != 0; k++) @(posedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_inst_cnt"}, 32'(inst_cnt), 32'(exp_icnt));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_ecnt));
    endtask

    task automatic chk_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_inst"}, out_inst, 32'd0);
        chk({tag, "_out_err"}, 32'(out_err), 32'd0);
        chk({tag, "_inst_cnt"}, 32'(inst_cnt), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic fields_t gen();
        logic [6:0]  opcs[9];
        fields_t     f;
        int          idx, c, v;
        logic [31:0] tmp;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                 OPC_ARI_ITYPE, OPC_ARI_RTYPE};
        idx = int'($urandom_range(0, 9));
        c   = int'($urandom_range(0, 7));
        f.opcode = (idx == 9) ? 7'($urandom) : opcs[idx];
        f.rd     = 5'($urandom);
        f.rs1    = 5'($urandom);
        f.rs2    = 5'($urandom);
        f.funct3 = 3'($urandom);
        f.funct7 = 7'($urandom);
        if (f.opcode == OPC_JALR && c != 1) f.funct3 = 3'd0;
        tmp = $urandom;
        case (f.opcode)
            OPC_LUI, OPC_AUIPC: f.imm = tmp & 32'hFFFF_F000;
            OPC_JAL: begin
                v = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
                f.imm = 32'(v) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                v = int'($urandom_range(0, 8191)) - 4096;
                f.imm = 32'(v) & 32'hFFFF_FFFE;
            end
            default: begin
                v = int'($urandom_range(0, 4095)) - 2048;
                f.imm = 32'(v);
                if (f.opcode == OPC_ARI_ITYPE && (f.funct3 == 3'd1 || f.funct3 == 3'd5))
                    f.imm = 32'($urandom_range(0, 31));
            end
        endcase
        if (c == 0) f.imm = tmp;
        return f;
    endfunction

    initial begin
        exp_t    e;
        fields_t v0, v1, v2;
        exp_t    e0;

        fork
            monitor();
            begin
                repeat (50000) @(posedge clk);
                $display("FAIL watchdog: simulation still running, expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        tbl[0]  = '{mk(OPC_LUI,       5, 0, 0, 3'd0, 7'h00, 32'h1234_5000), 32'h1234_52B7, 1'b0};
        tbl[1]  = '{mk(OPC_JAL,       1, 0, 0, 3'd0, 7'h00, 32'd8),         32'h0080_00EF, 1'b0};
        tbl[2]  = '{mk(OPC_BRANCH,    0, 1, 2, 3'd0, 7'h00, 32'hFFFF_FFFC), 32'hFE20_8EE3, 1'b0};
        tbl[3]  = '{mk(OPC_STORE,     0, 1, 2, 3'd2, 7'h00, 32'd12),        32'h0020_A623, 1'b0};
        tbl[4]  = '{mk(OPC_ARI_ITYPE, 1, 1, 0, 3'd0, 7'h00, 32'd2048),      32'h0000_0013, 1'b1};
        tbl[5]  = '{mk(OPC_AUIPC,     3, 0, 0, 3'd0, 7'h00, 32'h0000_1001), 32'h0000_0013, 1'b1};
        tbl[6]  = '{mk(OPC_AUIPC,     3, 0, 0, 3'd0, 7'h00, 32'hFFFF_F000), 32'hFFFF_F197, 1'b0};
        tbl[7]  = '{mk(OPC_ARI_ITYPE, 2, 3, 0, 3'd1, 7'h00, 32'd5),         32'h0051_9113, 1'b0};
        tbl[8]  = '{mk(OPC_ARI_ITYPE, 4, 4, 0, 3'd5, 7'h20, 32'd31),        32'h41F2_5213, 1'b0};
        tbl[9]  = '{mk(OPC_ARI_ITYPE, 2, 3, 0, 3'd1, 7'h00, 32'd32),        32'h0000_0013, 1'b1};
        tbl[10] = '{mk(OPC_ARI_RTYPE, 1, 2, 3, 3'd0, 7'h00, 32'hDEAD_BEEF), 32'h0031_00B3, 1'b0};
        tbl[11] = '{mk(OPC_LOAD,      5, 2, 0, 3'd2, 7'h00, 32'hFFFF_FFF8), 32'hFF81_2283, 1'b0};
        tbl[12] = '{mk(OPC_JALR,      1, 5, 0, 3'd0, 7'h00, 32'hFFFF_F800), 32'h8002_80E7, 1'b0};
        tbl[13] = '{mk(OPC_JALR,      1, 5, 0, 3'd1, 7'h00, 32'd0),         32'h0000_0013, 1'b1};
        tbl[14] = '{mk(OPC_JAL,       1, 0, 0, 3'd0, 7'h00, 32'd1),         32'h0000_0013, 1'b1};
        tbl[15] = '{mk(OPC_JAL,       1, 0, 0, 3'd0, 7'h00, 32'h0010_0000), 32'h0000_0013, 1'b1};
        tbl[16] = '{mk(OPC_JAL,       0, 0, 0, 3'd0, 7'h00, 32'hFFF0_0000), 32'h8000_006F, 1'b0};
        tbl[17] = '{mk(OPC_BRANCH,    0, 0, 0, 3'd1, 7'h00, 32'h0000_0FFE), 32'h7E00_1FE3, 1'b0};
        tbl[18] = '{mk(OPC_BRANCH,    0, 1, 2, 3'd0, 7'h00, 32'h0000_1000), 32'h0000_0013, 1'b1};
        tbl[19] = '{mk(7'h7F,         1, 1, 1, 3'd0, 7'h00, 32'd0),         32'h0000_0013, 1'b1};
        tbl[20] = '{mk(OPC_STORE,     0, 0, 0, 3'd2, 7'h00, 32'h0000_07FF), 32'h7E00_2FA3, 1'b0};
        tbl[21] = '{mk(OPC_ARI_ITYPE, 1, 0, 0, 3'd0, 7'h00, 32'hFFFF_F800), 32'h8000_0093, 1'b0};
        tbl[22] = '{mk(OPC_ARI_RTYPE, 1, 2, 3, 3'd0, 7'h20, 32'd0),         32'h4031_00B3, 1'b0};
        tbl[23] = '{mk(OPC_LOAD,      1, 2, 0, 3'd2, 7'h00, 32'hFFFF_F7FF), 32'h0000_0013, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_state("reset");

        // Latency: accept at edge N, S1 at N, out_valid visible after edge N+1.
        out_ready = 1'b1;
        in_f = tbl[0].f;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        sbq.push_back('{tbl[0].inst, tbl[0].err, tbl[0].f});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
        drain();

        for (int i = 1; i < 24; i++) begin
            e = '{tbl[i].inst, tbl[i].err, tbl[i].f};
            send(tbl[i].f, e);
        end
        drain();
        chk_counters("table");

        // Backpressure: two words fill the pipe, third waits, all leave in order.
        v0 = mk(OPC_ARI_RTYPE, 7, 1, 2, 3'd0, 7'h00, 32'd0);
        v1 = mk(OPC_ARI_RTYPE, 8, 1, 2, 3'd4, 7'h00, 32'd0);
        v2 = mk(OPC_ARI_RTYPE, 9, 1, 2, 3'd6, 7'h00, 32'd0);
        e0 = model(v0);
        out_ready = 1'b0;
        in_f = v0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_accept0", 32'(in_ready), 32'd1);
        sbq.push_back(e0);
        @(posedge clk);
        #1;
        in_f = v1;
        @(negedge clk);
        chk("bp_accept1", 32'(in_ready), 32'd1);
        sbq.push_back(model(v1));
        @(posedge clk);
        #1;
        in_f = v2;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
            chk("bp_stall_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_inst", out_inst, e0.inst);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept2", 32'(in_ready), 32'd1);
        sbq.push_back(model(v2));
        @(posedge clk);
        #1;
        drain();
        chk_counters("bp");

        // Reset while a word is being presented.
        out_ready = 1'b0;
        send(v0, model(v0));
        send(v1, model(v1));
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        exp_icnt = '0;
        exp_ecnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_state("midreset");
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_no_ghost", 32'(out_valid), 32'd0);

        rnd_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            v0 = gen();
            send(v0, model(v0));
        end
        rnd_rdy = 1'b0;
        drain();
        chk_counters("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
        $finish;
    end

endmodule
